// File: rtl/banco_registradores_if.sv
// Register-file access bus: write port plus two independent combinational read ports.
interface banco_registradores_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] read_register_1;
  logic [ADDR_WIDTH-1:0] read_register_2;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;

  modport master (
    output regWrite,
    output read_register_1,
    output read_register_2,
    output write_register,
    output write_data,
    input  read_data_1,
    input  read_data_2
  );

  modport slave (
    input  regWrite,
    input  read_register_1,
    input  read_register_2,
    input  write_register,
    input  write_data,
    output read_data_1,
    output read_data_2
  );
endinterface

// File: rtl/banco_registradores.sv
// MIPS general-purpose register file: 2**ADDR_WIDTH registers, two async read ports,
// one synchronous write port, register 0 hardwired to zero.
module banco_registradores #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  banco_registradores_if.slave bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (bus.regWrite && (bus.write_register != '0)) begin
      regs_d[bus.write_register] = bus.write_data;
    end
    // Entry 0 stays constant zero so it can be trimmed away.
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: a same-cycle write becomes visible only after the edge.
  always_comb begin
    bus.read_data_1 = (bus.read_register_1 == '0) ? '0 : regs_q[bus.read_register_1];
    bus.read_data_2 = (bus.read_register_2 == '0) ? '0 : regs_q[bus.read_register_2];
  end

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores against an array-based reference model.
module tb_banco_registradores;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [DW-1:0] model [32];

  banco_registradores_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  banco_registradores #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    return model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Drive a write request at the falling edge, let the rising edge take it, update the model.
  task automatic do_write(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus_if.regWrite       = we;
    bus_if.write_register = addr;
    bus_if.write_data     = data;
    @(posedge clk);
    #1;
    if (we && rst_n && addr != 0) model[addr] = data;
    bus_if.regWrite = 1'b0;
  endtask

  task automatic set_reads(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bus_if.read_register_1 = r1;
    bus_if.read_register_2 = r2;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    // A write attempted while reset is held must be ignored.
    bus_if.regWrite       = 1'b1;
    bus_if.write_register = 5'd4;
    bus_if.write_data     = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    bus_if.regWrite = 1'b0;
    rst_n = 1'b1;
    set_reads(5'd0, 5'd1);
    checks++;
    if (bus_if.read_data_1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd1: got %h expected %h", bus_if.read_data_1, 32'h0);
    end
    checks++;
    if (bus_if.read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd2: got %h expected %h", bus_if.read_data_2, 32'h0);
    end
    set_reads(5'd4, 5'd31);
    checks++;
    if (bus_if.read_data_1 !== 32'h0 || bus_if.read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_ignored: got %h/%h expected 0/0",
               bus_if.read_data_1, bus_if.read_data_2);
    end
  endtask

  task automatic test_basic_write();
    do_write(1'b1, 5'd2, 32'd7);
    set_reads(5'd2, 5'd1);
    checks++;
    if (bus_if.read_data_1 !== 32'd7) begin
      errors++;
      $display("FAIL basic_write: got %h expected %h", bus_if.read_data_1, 32'd7);
    end
    checks++;
    if (bus_if.read_data_2 !== 32'd0) begin
      errors++;
      $display("FAIL basic_other_reg: got %h expected %h", bus_if.read_data_2, 32'd0);
    end
  endtask

  task automatic test_write_disabled();
    do_write(1'b0, 5'd3, 32'hDEAD_BEEF);
    set_reads(5'd3, 5'd3);
    checks++;
    if (bus_if.read_data_1 !== 32'd0) begin
      errors++;
      $display("FAIL write_disabled: got %h expected %h", bus_if.read_data_1, 32'd0);
    end
  endtask

  task automatic test_zero_protect();
    do_write(1'b1, 5'd0, 32'h1234_5678);
    set_reads(5'd0, 5'd0);
    checks++;
    if (bus_if.read_data_1 !== 32'd0 || bus_if.read_data_2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_protect: got %h/%h expected 0/0", bus_if.read_data_1, bus_if.read_data_2);
    end
  endtask

  task automatic test_read_during_write();
    do_write(1'b1, 5'd5, 32'h11);
    @(negedge clk);
    bus_if.regWrite       = 1'b1;
    bus_if.write_register = 5'd5;
    bus_if.write_data     = 32'h22;
    set_reads(5'd5, 5'd5);
    checks++;
    if (bus_if.read_data_1 !== 32'h11) begin
      errors++;
      $display("FAIL rdw_before_edge: got %h expected %h", bus_if.read_data_1, 32'h11);
    end
    @(posedge clk);
    #1;
    model[5] = 32'h22;
    bus_if.regWrite = 1'b0;
    checks++;
    if (bus_if.read_data_1 !== 32'h22 || bus_if.read_data_2 !== 32'h22) begin
      errors++;
      $display("FAIL rdw_after_edge: got %h/%h expected %h", bus_if.read_data_1,
               bus_if.read_data_2, 32'h22);
    end
  endtask

  task automatic test_async_reset();
    do_write(1'b1, 5'd2, 32'd7);
    do_write(1'b1, 5'd31, 32'hFFFF_FFFF);
    set_reads(5'd2, 5'd31);
    checks++;
    if (bus_if.read_data_1 !== 32'd7 || bus_if.read_data_2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL async_pre: got %h/%h expected %h/%h", bus_if.read_data_1,
               bus_if.read_data_2, 32'd7, 32'hFFFF_FFFF);
    end
    // Now at posedge+2; reset pulse sits well before the next rising edge.
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus_if.read_data_1 !== 32'd0 || bus_if.read_data_2 !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%h expected 0/0", bus_if.read_data_1, bus_if.read_data_2);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [DW-1:0] v;
    for (int i = 1; i < 32; i++) begin
      v = {i[7:0], 24'($urandom)};
      do_write(1'b1, i[AW-1:0], v);
    end
    for (int i = 0; i < 32; i++) begin
      set_reads(i[AW-1:0], 5'(31 - i));
      checks++;
      if (bus_if.read_data_1 !== ref_read(i[AW-1:0]) ||
          bus_if.read_data_2 !== ref_read(5'(31 - i))) begin
        errors++;
        $display("FAIL sweep[%0d]: got %h/%h expected %h/%h", i, bus_if.read_data_1,
                 bus_if.read_data_2, ref_read(i[AW-1:0]), ref_read(5'(31 - i)));
      end
    end
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] wa, r1, r2;
    logic [DW-1:0] wd;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom);
      wa = AW'($urandom);
      wd = (n % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      r1 = (n % 3 == 0) ? wa : AW'($urandom);
      r2 = (n % 5 == 0) ? r1 : AW'($urandom);
      @(negedge clk);
      bus_if.regWrite       = we;
      bus_if.write_register = wa;
      bus_if.write_data     = wd;
      set_reads(r1, r2);
      checks++;
      if (bus_if.read_data_1 !== ref_read(r1) || bus_if.read_data_2 !== ref_read(r2)) begin
        errors++;
        $display("FAIL rand_pre[%0d]: got %h/%h expected %h/%h", n, bus_if.read_data_1,
                 bus_if.read_data_2, ref_read(r1), ref_read(r2));
      end
      @(posedge clk);
      #1;
      if (we && wa != 0) model[wa] = wd;
      checks++;
      if (bus_if.read_data_1 !== ref_read(r1) || bus_if.read_data_2 !== ref_read(r2)) begin
        errors++;
        $display("FAIL rand_post[%0d]: got %h/%h expected %h/%h", n, bus_if.read_data_1,
                 bus_if.read_data_2, ref_read(r1), ref_read(r2));
      end
    end
    bus_if.regWrite = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus_if.regWrite        = 1'b0;
    bus_if.read_register_1 = '0;
    bus_if.read_register_2 = '0;
    bus_if.write_register  = '0;
    bus_if.write_data      = '0;
    test_reset();
    test_basic_write();
    test_write_disabled();
    test_zero_protect();
    test_read_during_write();
    test_async_reset();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banco_registradores.md
Name: banco_registradores

Overview:
MIPS general-purpose register file: 32 registers of 32 bits, two asynchronous read ports and one synchronous write port. Sits in the decode stage of the MIPS datapath. Feeds ALU operands (rs/rt) and accepts write-back results from the ALU or memory path. Register $0 reads as zero at all times.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH (32)

Ports:
clk  input  1  system clock; write occurs on rising edge
rst_n  input  1  asynchronous active-low reset; clears all registers
regWrite  input  1  write enable from control unit
read_register_1  input  ADDR_WIDTH  read port 1 index (rs)
read_register_2  input  ADDR_WIDTH  read port 2 index (rt)
write_register  input  ADDR_WIDTH  write index (rd/rt from dest mux)
write_data  input  DATA_WIDTH  write-back value
read_data_1  output  DATA_WIDTH  contents of read_register_1
read_data_2  output  DATA_WIDTH  contents of read_register_2

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Storage: 32 x 32-bit registers, index 0..31.
- Reset: rst_n low -> all 32 registers = 0 immediately, independent of clk. Held while rst_n low; writes ignored during reset. Release takes effect at the next rising clk edge with rst_n high.
- Write: on rising clk edge with rst_n=1 and regWrite=1 -> reg[write_register] <= write_data. regWrite=0 -> no register changes.
- Register 0: writes to index 0 discarded. read of index 0 always returns 0 regardless of any write attempt.
- Read: purely combinational. read_data_N = (index==0) ? 0 : reg[index]. Changes in the same delta as index or stored contents change. No clock latency.
- Read-during-write, same index, same cycle: read returns the OLD value until the rising edge. After the edge, the new value appears combinationally. No internal bypass; forwarding is the pipeline's job.
- Both read ports are independent. The same index on both ports returns identical data.
- Outputs after reset: read_data_1 = read_data_2 = 0 for any index.
- Widths exact: no sign/zero extension inside the block. write_data stored verbatim (all 32 bits, including 0xFFFFFFFF).
- No X propagation from unwritten registers: every register is defined after reset.

Test Plan:
- Reset then read: assert rst_n=0, release. read_register_1=0, read_register_2=1 -> read_data_1=0, read_data_2=0.
- Basic write: regWrite=1, write_register=2, write_data=7, one rising edge. Then read_register_1=2 -> read_data_1=7. read_register_2=1 still 0.
- Write disabled: regWrite=0, write_register=3, write_data=0xDEADBEEF, edge. read reg 3 -> 0.
- $zero protection: regWrite=1, write_register=0, write_data=0x12345678, edge. read reg 0 on both ports -> 0.
- Read-during-write: reg 5 holds 0x11. Set write_register=5, write_data=0x22, regWrite=1, read_register_1=5. Before edge -> 0x11; after edge -> 0x22.
- Async reset mid-operation: registers 2 and 31 written (7, 0xFFFFFFFF). Pulse rst_n low between clock edges -> both read 0 immediately, without waiting for a clk edge. Also sweep all 31 writable registers with unique values and read back on both ports.
